// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit counter
// encoding, reset/allocation counter values and the table entry record.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  // Entry layout for the default configuration (XLEN=32, IDX_BITS=4).
  localparam int unsigned BP_XLEN     = 32;
  localparam int unsigned BP_IDX_BITS = 4;

  typedef struct packed {
    logic                            valid;
    logic [BP_XLEN-BP_IDX_BITS-3:0]  tag;
    logic [BP_XLEN-1:0]              target;
    ctr_t                            ctr;
  } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t next_ctr
);

  // Step one state towards the outcome, holding at either end.
  always_comb begin
    next_ctr = ctr;
    unique case (ctr)
      CTR_SNT: next_ctr = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: next_ctr = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  next_ctr = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  next_ctr = taken ? CTR_ST  : CTR_WT;
      default: next_ctr = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: combinational lookup of the fetch
// PC, trained by resolved branches from EX.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = XLEN - IDX_BITS - 2;

  // Same layout as bp_entry_t, sized from this instance's parameters.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    ctr_t             ctr;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};

  entry_t              table_q [ENTRIES];

  logic [IDX_BITS-1:0] fidx;
  logic [TAG_W-1:0]    ftag;
  entry_t              fent;
  logic                fhit;

  logic [IDX_BITS-1:0] uidx;
  logic [TAG_W-1:0]    utag;
  entry_t              uent;
  logic                uhit;
  ctr_t                ctr_nxt;

  // Word-aligned PCs: the byte-offset bits carry no information here.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Lookup: index/tag split of the fetch PC and the hit compare.
  always_comb begin
    fidx        = fetch_pc[IDX_BITS+1:2];
    ftag        = fetch_pc[XLEN-1:IDX_BITS+2];
    fent        = table_q[fidx];
    fhit        = fent.valid && (fent.tag == ftag);
    pred_taken  = !rst && fhit && fent.ctr[1];
    pred_target = (!rst && fhit) ? fent.target : '0;
  end

  // Update path: locate the resolved branch's entry and decide hit/miss.
  always_comb begin
    uidx = upd_pc[IDX_BITS+1:2];
    utag = upd_pc[XLEN-1:IDX_BITS+2];
    uent = table_q[uidx];
    uhit = uent.valid && (uent.tag == utag);
  end

  sat_counter2 u_ctr (
    .ctr      (uent.ctr),
    .taken    (upd_taken),
    .next_ctr (ctr_nxt)
  );

  // Table state: train on hits, allocate on taken misses, ignore not-taken misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      table_q <= '{default: ENTRY_RESET};
    end else if (upd_valid) begin
      if (uhit) begin
        table_q[uidx].ctr <= ctr_nxt;
        if (upd_taken) begin
          table_q[uidx].target <= upd_target;
        end
      end else if (upd_taken) begin
        table_q[uidx] <= '{valid: 1'b1, tag: utag, target: upd_target, ctr: CTR_ALLOC};
      end
    end
  end

endmodule
